linebuffer_ctrl: RTL and testbench

- Sequencer for the line-buffered sliding-window datapath (linebuffer, KERNEL_W rows deep).
- Accepts a raster pixel stream under valid/ready and drives the linebuffer write/read enables.
- Tracks column and row position and asserts window-valid only when a full KERNEL_W x KERNEL_W window exists.
- Sits between the pixel source and the linebuffer/kernel datapath; one instance per filter pipeline.

---
 rtl/linebuffer_ctrl.sv | 143 ++++++++++++++
 tb/tb_linebuffer_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/linebuffer_ctrl.sv
// Sequencer for the sliding-window linebuffer: accepts a raster pixel stream,
// drives linebuffer write/read enables and flags positions that complete a full window.
module linebuffer_ctrl #(
  parameter int DATA_W   = 8,
  parameter int KERNEL_W = 3,
  parameter int IMG_W    = 512,
  parameter int IMG_H    = 512,
  localparam int COL_W   = $clog2(IMG_W),
  localparam int ROW_W   = $clog2(IMG_H)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] pix_data_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] lb_data_o,
  output logic              lb_wr_valid_o,
  output logic              lb_rd_valid_o,
  output logic              win_valid_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_KM1  = COL_W'(KERNEL_W - 1);
  localparam logic [ROW_W-1:0] ROW_KM1  = ROW_W'(KERNEL_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic              r_busy;
  logic              r_frame_done;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_lb_data;
  logic              r_lb_wr;
  logic              r_lb_rd;
  logic              r_win;
  logic [COL_W-1:0]  r_col_o;
  logic [ROW_W-1:0]  r_row_o;

  logic w_ready;
  logic w_acc;
  logic w_col_last;
  logic w_row_last;
  logic w_fill_end;
  logic w_frame_end;

  assign w_ready     = ((r_state == S_FILL) || (r_state == S_RUN)) && out_ready_i;
  assign w_acc       = pix_valid_i && w_ready;
  assign w_col_last  = (r_col == COL_LAST);
  assign w_row_last  = (r_row == ROW_LAST);
  assign w_fill_end  = (r_state == S_FILL) && (r_row == ROW_KM1) && (r_col == '0);
  assign w_frame_end = (r_state == S_RUN) && w_col_last && w_row_last;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_FILL;
            r_busy  <= 1'b1;
          end
        end
        S_FILL: begin
          if (w_acc && w_fill_end) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_acc && w_frame_end) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
        end
        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

  // Position of the next pixel to be accepted; wraps to (0,0) after the frame's last pixel.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // The pixel that completes the fill (first pixel of row KERNEL_W-1) is also the first read.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_lb_data <= '0;
      r_lb_wr   <= 1'b0;
      r_lb_rd   <= 1'b0;
      r_win     <= 1'b0;
      r_col_o   <= '0;
      r_row_o   <= '0;
    end else begin
      r_lb_wr <= w_acc;
      r_lb_rd <= w_acc && ((r_state == S_RUN) || w_fill_end);
      r_win   <= w_acc && (r_row >= ROW_KM1) && (r_col >= COL_KM1);
      if (w_acc) begin
        r_lb_data <= pix_data_i;
        r_col_o   <= r_col;
        r_row_o   <= r_row;
      end
    end
  end

  assign pix_ready_o   = w_ready;
  assign lb_data_o     = r_lb_data;
  assign lb_wr_valid_o = r_lb_wr;
  assign lb_rd_valid_o = r_lb_rd;
  assign win_valid_o   = r_win;
  assign col_o         = r_col_o;
  assign row_o         = r_row_o;
  assign busy_o        = r_busy;
  assign frame_done_o  = r_frame_done;

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// Directed bench for linebuffer_ctrl on an 8x6 image with a 3x3 kernel.
module tb_linebuffer_ctrl;

  localparam int DW = 8;
  localparam int KW = 3;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int NPIX = IW * IH;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] pix_data_i = '0;
  logic          pix_valid_i = 1'b0;
  logic          pix_ready_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] lb_data_o;
  logic          lb_wr_valid_o;
  logic          lb_rd_valid_o;
  logic          win_valid_o;
  logic [2:0]    col_o;
  logic [2:0]    row_o;
  logic          busy_o;
  logic          frame_done_o;

  int checks = 0;
  int errors = 0;
  int wr_cnt, win_cnt, first_rd, first_win;

  linebuffer_ctrl #(.DATA_W(DW), .KERNEL_W(KW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk_i        (clk),
    .arst_n_i     (arst_n),
    .start_i      (start_i),
    .pix_data_i   (pix_data_i),
    .pix_valid_i  (pix_valid_i),
    .pix_ready_o  (pix_ready_o),
    .out_ready_i  (out_ready_i),
    .lb_data_o    (lb_data_o),
    .lb_wr_valid_o(lb_wr_valid_o),
    .lb_rd_valid_o(lb_rd_valid_o),
    .win_valid_o  (win_valid_o),
    .col_o        (col_o),
    .row_o        (row_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int n);
    return DW'((n * 37 + 5) & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the registered outputs for the cycle just clocked; pn is the pixel index accepted then.
  task automatic check_out(input logic pacc, input int pn, input int held);
    if (pacc) begin
      chk("wr_valid", 32'(lb_wr_valid_o), 1);
      chk("lb_data", 32'(lb_data_o), 32'(pat(pn)));
      chk("col", 32'(col_o), pn % IW);
      chk("row", 32'(row_o), pn / IW);
      chk("rd_valid", 32'(lb_rd_valid_o), 32'(pn >= (KW - 1) * IW));
      chk("win_valid", 32'(win_valid_o), 32'((pn / IW >= KW - 1) && (pn % IW >= KW - 1)));
    end else begin
      chk("wr_idle", 32'(lb_wr_valid_o), 0);
      chk("rd_idle", 32'(lb_rd_valid_o), 0);
      chk("win_idle", 32'(win_valid_o), 0);
      if (held >= 0) begin
        chk("col_hold", 32'(col_o), held % IW);
        chk("row_hold", 32'(row_o), held / IW);
      end
    end
    if (lb_wr_valid_o) wr_cnt++;
    if (lb_rd_valid_o && first_rd < 0) first_rd = pn;
    if (win_valid_o) begin
      win_cnt++;
      if (first_win < 0) first_win = pn;
    end
  endtask

  // mode 0: back-to-back; 1: out_ready toggling with start_i held high; 2: random valid gaps.
  task automatic run_frame(input int mode);
    int n, pn, cyc;
    logic pacc, ordy, vld;
    n = 0; pn = 0; cyc = 0; pacc = 1'b0;
    wr_cnt = 0; win_cnt = 0; first_rd = -1; first_win = -1;
    start_i = 1'b1; pix_valid_i = 1'b0; out_ready_i = 1'b1;
    tick();
    start_i = (mode == 1);
    chk("busy_after_start", 32'(busy_o), 1);
    while (n < NPIX) begin
      if (cyc > 600) begin
        chk("frame_timeout", n, NPIX);
        break;
      end
      check_out(pacc, pn, n - 1);
      chk("busy_run", 32'(busy_o), 1);
      chk("done_run", 32'(frame_done_o), 0);
      ordy = (mode == 1) ? (cyc % 2 == 0) : 1'b1;
      vld  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready_i = ordy; pix_valid_i = vld; pix_data_i = pat(n);
      #1;
      chk("pix_ready", 32'(pix_ready_o), 32'(ordy));
      pacc = vld && ordy; pn = n;
      if (pacc) n++;
      cyc++;
      tick();
    end
    check_out(pacc, pn, NPIX - 1);
    chk("frame_done_hi", 32'(frame_done_o), 1);
    chk("busy_in_done", 32'(busy_o), 1);
    start_i = 1'b1; pix_valid_i = 1'b1; out_ready_i = 1'b1;
    #1;
    chk("ready_in_done", 32'(pix_ready_o), 0);
    tick();
    chk("frame_done_lo", 32'(frame_done_o), 0);
    chk("idle_start_ignored", 32'(busy_o), 0);
    chk("no_wr_after_done", 32'(lb_wr_valid_o), 0);
    chk("ready_in_idle", 32'(pix_ready_o), 0);
    chk("col_last", 32'(col_o), IW - 1);
    chk("row_last", 32'(row_o), IH - 1);
    start_i = 1'b0; pix_valid_i = 1'b0;
    chk("wr_count", wr_cnt, NPIX);
    chk("win_count", win_cnt, (IH - KW + 1) * (IW - KW + 1));
    chk("first_rd", first_rd, (KW - 1) * IW);
    chk("first_win", first_win, (KW - 1) * IW + KW - 1);
  endtask

  initial begin
    #2 arst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_wr", 32'(lb_wr_valid_o), 0);
    chk("rst_win", 32'(win_valid_o), 0);
    chk("rst_col", 32'(col_o), 0);
    chk("rst_row", 32'(row_o), 0);
    chk("rst_ready", 32'(pix_ready_o), 0);
    tick();
    arst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy_o), 0);

    // Partial frame into RUN, then asynchronous reset mid-frame.
    start_i = 1'b1; out_ready_i = 1'b1;
    tick();
    start_i = 1'b0; pix_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      pix_data_i = pat(i);
      tick();
    end
    chk("pre_rst_busy", 32'(busy_o), 1);
    chk("pre_rst_rd", 32'(lb_rd_valid_o), 1);
    #2 arst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy_o), 0);
    chk("midrst_wr", 32'(lb_wr_valid_o), 0);
    chk("midrst_rd", 32'(lb_rd_valid_o), 0);
    chk("midrst_win", 32'(win_valid_o), 0);
    chk("midrst_col", 32'(col_o), 0);
    chk("midrst_row", 32'(row_o), 0);
    chk("midrst_data", 32'(lb_data_o), 0);
    chk("midrst_ready", 32'(pix_ready_o), 0);
    tick();
    arst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy_o), 0);
    chk("post_rst_wr", 32'(lb_wr_valid_o), 0);
    pix_valid_i = 1'b0;

    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
